// File: rtl/bsg_parallel_in_serial_out_dynamic_pkg.sv
// Shared helpers for the dynamic parallel-in / serial-out buffer.
// No ports; provides the width helper used to size counters from parameters.
package bsg_parallel_in_serial_out_dynamic_pkg;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_parallel_in_serial_out_dynamic_if.sv
// Handshake bundle for the dynamic parallel-in / serial-out buffer.
//   in_cnt_i : words offered this cycle (0..in_els_p)
//   data_i   : offered words, word 0 oldest
//   ready_o  : producer may transfer any in_cnt_i this cycle
//   v_o      : data_o holds a valid word
//   data_o   : oldest word in the block
//   yumi_i   : consumer takes data_o this cycle
// slave modport is the buffer side; master is the producer/consumer side.
interface bsg_parallel_in_serial_out_dynamic_if
  import bsg_parallel_in_serial_out_dynamic_pkg::*;
  #(parameter int width_p  = 1,
    parameter int in_els_p = 1);

  localparam int in_cnt_w = cnt_width(in_els_p);

  logic [in_cnt_w-1:0]                in_cnt_i;
  logic [in_els_p-1:0][width_p-1:0]   data_i;
  logic                               ready_o;
  logic                               v_o;
  logic [width_p-1:0]                 data_o;
  logic                               yumi_i;

  modport slave  (input  in_cnt_i, data_i, yumi_i,
                  output ready_o, v_o, data_o);
  modport master (output in_cnt_i, data_i, yumi_i,
                  input  ready_o, v_o, data_o);

endinterface

// File: rtl/bsg_parallel_in_serial_out_dynamic.sv
// Dynamic parallel-in / serial-out buffer.
// Accepts 0..in_els_p words per cycle (all or nothing) into an els_p-deep
// flop shift register and emits one word per yumi, oldest first. When the
// buffer is empty the oldest offered word bypasses straight to data_o.
// Ports:
//   clk_i     : clock, rising edge
//   reset_n_i : asynchronous active-low reset (clears the word count only)
//   io        : slave side of the handshake bundle
module bsg_parallel_in_serial_out_dynamic
  import bsg_parallel_in_serial_out_dynamic_pkg::*;
  #(parameter int width_p  = -1,
    parameter int els_p    = -1,
    parameter int in_els_p = els_p)
  (input  logic clk_i,
   input  logic reset_n_i,
   bsg_parallel_in_serial_out_dynamic_if.slave io);

  localparam int cnt_w    = cnt_width(els_p);
  localparam int in_cnt_w = cnt_width(in_els_p);
  // Wide enough for stored + accepted before the dequeue is subtracted.
  localparam int sum_w    = cnt_width(els_p + in_els_p);

  logic [cnt_w-1:0]                num_els_q, num_els_d;
  logic [sum_w-1:0]                num_sum;
  logic [els_p-1:0][width_p-1:0]   slots_q, slots_d;
  // Stored words followed by accepted words; one extra slot so the
  // dequeue shift can read index i+1 for every kept slot.
  logic [els_p:0][width_p-1:0]     merged;
  logic                            ready;
  logic [in_cnt_w-1:0]             acc_cnt;
  logic                            stored_v;

  // Depends only on registered count: no path from yumi_i or in_cnt_i.
  assign ready    = (els_p - int'(num_els_q)) >= in_els_p;
  assign acc_cnt  = (ready && (io.in_cnt_i != '0)) ? io.in_cnt_i : '0;
  assign stored_v = (num_els_q != '0);

  assign io.ready_o = ready;
  assign io.v_o     = stored_v || (acc_cnt != '0);
  assign io.data_o  = stored_v ? slots_q[0] : io.data_i[0];

  always_comb begin
    merged = '0;
    for (int i = 0; i < els_p; i++) merged[i] = slots_q[i];
    // Accepted word k lands right after the stored words.
    for (int i = 0; i <= els_p; i++)
      for (int k = 0; k < in_els_p; k++)
        if ((int'(num_els_q) + k == i) && (k < int'(acc_cnt)))
          merged[i] = io.data_i[k];
    // A dequeue drops the head; with an empty store that head is the
    // bypassed word, so words 1.. settle into slots 0.. .
    for (int i = 0; i < els_p; i++)
      slots_d[i] = io.yumi_i ? merged[i+1] : merged[i];
  end

  assign num_sum   = sum_w'(num_els_q) + sum_w'(acc_cnt) - sum_w'(io.yumi_i);
  assign num_els_d = num_sum[cnt_w-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) num_els_q <= '0;
    else            num_els_q <= num_els_d;
  end

  // Storage is deliberately unreset; the count alone defines validity.
  always_ff @(posedge clk_i) begin
    slots_q <= slots_d;
  end

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(io.yumi_i && !io.v_o))
    else $error("yumi_i asserted while v_o is low");

  a_in_cnt_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    int'(io.in_cnt_i) <= in_els_p)
    else $error("in_cnt_i exceeds in_els_p");

endmodule

// File: tb/tb_bsg_parallel_in_serial_out_dynamic.sv
module tb_bsg_parallel_in_serial_out_dynamic;

  localparam int W  = 8;
  localparam int E  = 4;
  localparam int IN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_parallel_in_serial_out_dynamic_if #(.width_p(W), .in_els_p(IN)) bus ();

  bsg_parallel_in_serial_out_dynamic #(.width_p(W), .els_p(E), .in_els_p(IN)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .io(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an ordered queue of buffered words.
  logic [W-1:0] q[$];
  int           cur_c;
  logic [W-1:0] cur_a, cur_b;
  logic         cur_y;

  typedef struct {
    string        nm;
    int           cnt;
    logic [W-1:0] d0, d1;
    logic         y;
    logic         er, ev;
    logic [W-1:0] ed;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int c, input logic [W-1:0] a, input logic [W-1:0] b, input logic y);
    cur_c = c; cur_a = a; cur_b = b; cur_y = y;
    bus.in_cnt_i = 2'(c);
    bus.data_i   = {b, a};
    bus.yumi_i   = y;
    #2;
  endtask

  // Apply the model's rules for the cycle just driven, then clock.
  task automatic tick();
    bit r;
    r = (E - q.size()) >= IN;
    if (r && cur_c > 0) q.push_back(cur_a);
    if (r && cur_c > 1) q.push_back(cur_b);
    if (cur_y && q.size() > 0) void'(q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_cnt_i = '0;
    bus.data_i   = '0;
    bus.yumi_i   = 1'b0;

    // Directed table, starting from empty.
    tbl.push_back('{"bypass",      1, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5});
    tbl.push_back('{"bypass_empty",0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{"fill1",       2, 8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01});
    tbl.push_back('{"fill2",       2, 8'h03, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01});
    tbl.push_back('{"full_yumi",   2, 8'hEE, 8'hEF, 1'b1, 1'b0, 1'b1, 8'h01});
    tbl.push_back('{"three_held",  2, 8'hDD, 8'hDC, 1'b0, 1'b0, 1'b1, 8'h02});
    tbl.push_back('{"deq2",        0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02});
    tbl.push_back('{"deq3",        0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03});
    tbl.push_back('{"deq4",        0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04});
    tbl.push_back('{"drained",     0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{"split_a",     2, 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 8'h10});
    tbl.push_back('{"split_b",     0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20});
    tbl.push_back('{"split_deq",   0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h20});
    tbl.push_back('{"split_empty", 0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00});

    #22;
    chk("rst_ready", 8'(bus.ready_o), 8'h01);
    chk("rst_v",     8'(bus.v_o),     8'h00);
    rst_n = 1'b1;
    #1;
    chk("post_rst_v", 8'(bus.v_o), 8'h00);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].cnt, tbl[i].d0, tbl[i].d1, tbl[i].y);
      chk({tbl[i].nm, "_ready"}, 8'(bus.ready_o), 8'(tbl[i].er));
      chk({tbl[i].nm, "_v"},     8'(bus.v_o),     8'(tbl[i].ev));
      if (tbl[i].ev) chk({tbl[i].nm, "_data"}, bus.data_o, tbl[i].ed);
      tick();
    end

    // Mid-operation reset with three words held.
    drive(2, 8'hA1, 8'hA2, 1'b0); tick();
    drive(1, 8'hA3, 8'h00, 1'b0); tick();
    drive(0, 8'h00, 8'h00, 1'b0);
    chk("pre_rst_head", bus.data_o, 8'hA1);
    chk("pre_rst_ready", 8'(bus.ready_o), 8'h00);
    rst_n = 1'b0;
    #1;
    chk("midrst_v",     8'(bus.v_o),     8'h00);
    chk("midrst_ready", 8'(bus.ready_o), 8'h01);
    #1;
    rst_n = 1'b1;
    q.delete();
    #1;
    chk("rel_v", 8'(bus.v_o), 8'h00);
    tick();
    drive(0, 8'h00, 8'h00, 1'b0);
    chk("no_stale_v", 8'(bus.v_o), 8'h00);
    tick();
    drive(1, 8'h77, 8'h00, 1'b1);
    chk("new_word", bus.data_o, 8'h77);
    tick();
    drive(0, 8'h00, 8'h00, 1'b0);
    chk("new_drained_v", 8'(bus.v_o), 8'h00);
    tick();

    // Random soak against the queue model.
    for (int n = 0; n < 10000; n++) begin
      int           c;
      logic [W-1:0] a, b, ed;
      bit           r, ev, y;
      c  = $urandom_range(0, IN);
      a  = 8'($urandom);
      b  = 8'($urandom);
      r  = (E - q.size()) >= IN;
      ev = (q.size() > 0) || (r && c > 0);
      ed = (q.size() > 0) ? q[0] : a;
      y  = ev && ($urandom_range(0, 2) != 0);
      drive(c, a, b, y);
      chk("rnd_ready", 8'(bus.ready_o), 8'(r));
      chk("rnd_v",     8'(bus.v_o),     8'(ev));
      if (ev) chk("rnd_data", bus.data_o, ed);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
